// File: rtl/qdec_bin_arb_if.sv
// Bus bundle between the bin requesters / arithmetic engine and qdec_bin_arb.
// master: environment side (requesters and engine); slave: the arbiter.
interface qdec_bin_arb_if;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [39:0] ctx_addr_in;
    logic [3:0]  ep_mode_in;
    logic [3:0]  gnt;
    logic        bin_out;
    logic [3:0]  bin_vld;
    logic [9:0]  eng_ctx_addr;
    logic        eng_ctx_addr_vld;
    logic        eng_dec_run;
    logic        eng_ep_mode;
    logic        eng_dec_rdy;
    logic        eng_bin;
    logic        eng_bin_vld;
    logic        busy;
    logic        timeout_err;

    modport master (
        output req, lock, ctx_addr_in, ep_mode_in, eng_dec_rdy, eng_bin, eng_bin_vld,
        input  gnt, bin_out, bin_vld, eng_ctx_addr, eng_ctx_addr_vld, eng_dec_run,
               eng_ep_mode, busy, timeout_err
    );

    modport slave (
        input  req, lock, ctx_addr_in, ep_mode_in, eng_dec_rdy, eng_bin, eng_bin_vld,
        output gnt, bin_out, bin_vld, eng_ctx_addr, eng_ctx_addr_vld, eng_dec_run,
               eng_ep_mode, busy, timeout_err
    );
endinterface

// File: rtl/qdec_bin_arb.sv
// Round-robin arbiter sharing one CABAC arithmetic engine between four bin requesters.
// Optional WAIT_BIN watchdog enabled by defining QDEC_BIN_ARB_TIMEOUT_EN.
module qdec_bin_arb (
    input logic           clk,
    input logic           rst_n,
    qdec_bin_arb_if.slave arb_io
);

    typedef enum logic [2:0] {StIdle, StIssue, StRun, StWaitBin, StDone, StLocked} state_e;

    state_e     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] rr_ptr_q, rr_ptr_d;
    logic [3:0] gnt_q, gnt_d;
    logic [3:0] bin_vld_q, bin_vld_d;
    logic       bin_out_q, bin_out_d;
    logic [9:0] ctx_addr_q, ctx_addr_d;
    logic       ctx_vld_q, ctx_vld_d;
    logic       dec_run_q, dec_run_d;
    logic       ep_mode_q, ep_mode_d;
    logic       busy_q, busy_d;
    logic       arb_hit;
    logic [1:0] arb_idx;
`ifdef QDEC_BIN_ARB_TIMEOUT_EN
    logic [7:0] wdog_q, wdog_d;
    logic       timeout_q, timeout_d;
`endif

    // Round-robin search starting one past the last served requester.
    always_comb begin
        arb_hit = 1'b0;
        arb_idx = rr_ptr_q;
        for (int k = 1; k <= 4; k++) begin
            if (!arb_hit && arb_io.req[rr_ptr_q + k[1:0]]) begin
                arb_hit = 1'b1;
                arb_idx = rr_ptr_q + k[1:0];
            end
        end
    end

    // Next-state logic; every output is computed here and registered below.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_d      = gnt_q;
        bin_vld_d  = 4'b0000;
        bin_out_d  = bin_out_q;
        ctx_addr_d = ctx_addr_q;
        ctx_vld_d  = 1'b0;
        dec_run_d  = 1'b0;
        ep_mode_d  = ep_mode_q;
`ifdef QDEC_BIN_ARB_TIMEOUT_EN
        timeout_d  = 1'b0;
        wdog_d     = (state_q == StWaitBin) ? wdog_q + 8'd1 : 8'd0;
`endif
        unique case (state_q)
            StIdle: begin
                if (arb_hit) begin
                    owner_d = arb_idx;
                    gnt_d   = 4'b0001 << arb_idx;
                    state_d = StIssue;
                end
            end
            StIssue: state_d = StRun;
            StRun: begin
                // dec_run_q marks the pulse cycle; stay in RUN while it is high.
                if (dec_run_q) begin
                    state_d = StWaitBin;
                end else if (arb_io.eng_dec_rdy) begin
                    dec_run_d = 1'b1;
                end
            end
            StWaitBin: begin
                if (arb_io.eng_bin_vld) begin
                    bin_out_d = arb_io.eng_bin;
                    bin_vld_d = gnt_q;
                    state_d   = StDone;
                end
`ifdef QDEC_BIN_ARB_TIMEOUT_EN
                else if (wdog_q == 8'd254) begin
                    timeout_d = 1'b1;
                    gnt_d     = 4'b0000;
                    rr_ptr_d  = owner_q;
                    state_d   = StIdle;
                end
`endif
            end
            StDone: begin
                rr_ptr_d = owner_q;
                if (arb_io.lock[owner_q]) begin
                    state_d = StLocked;
                end else begin
                    gnt_d   = 4'b0000;
                    state_d = StIdle;
                end
            end
            StLocked: begin
                if (arb_io.req[owner_q]) begin
                    state_d = StIssue;
                end else if (!arb_io.lock[owner_q]) begin
                    gnt_d   = 4'b0000;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Engine-side fields load on ISSUE entry and hold for the transaction.
        if (state_d == StIssue) begin
            ctx_addr_d = arb_io.ctx_addr_in[int'(owner_d) * 10 +: 10];
            ctx_vld_d  = !arb_io.ep_mode_in[owner_d];
            ep_mode_d  = arb_io.ep_mode_in[owner_d];
        end else if (state_d == StIdle) begin
            ep_mode_d  = 1'b0;
        end
        busy_d = (state_d != StIdle);
    end

    // State and output registers, synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            owner_q    <= 2'd0;
            rr_ptr_q   <= 2'd3;
            gnt_q      <= 4'b0000;
            bin_vld_q  <= 4'b0000;
            bin_out_q  <= 1'b0;
            ctx_addr_q <= 10'd0;
            ctx_vld_q  <= 1'b0;
            dec_run_q  <= 1'b0;
            ep_mode_q  <= 1'b0;
            busy_q     <= 1'b0;
`ifdef QDEC_BIN_ARB_TIMEOUT_EN
            wdog_q     <= 8'd0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_q      <= gnt_d;
            bin_vld_q  <= bin_vld_d;
            bin_out_q  <= bin_out_d;
            ctx_addr_q <= ctx_addr_d;
            ctx_vld_q  <= ctx_vld_d;
            dec_run_q  <= dec_run_d;
            ep_mode_q  <= ep_mode_d;
            busy_q     <= busy_d;
`ifdef QDEC_BIN_ARB_TIMEOUT_EN
            wdog_q     <= wdog_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    assign arb_io.gnt              = gnt_q;
    assign arb_io.bin_out          = bin_out_q;
    assign arb_io.bin_vld          = bin_vld_q;
    assign arb_io.eng_ctx_addr     = ctx_addr_q;
    assign arb_io.eng_ctx_addr_vld = ctx_vld_q;
    assign arb_io.eng_dec_run      = dec_run_q;
    assign arb_io.eng_ep_mode      = ep_mode_q;
    assign arb_io.busy             = busy_q;
`ifdef QDEC_BIN_ARB_TIMEOUT_EN
    assign arb_io.timeout_err      = timeout_q;
`else
    assign arb_io.timeout_err      = 1'b0;
`endif

endmodule

// File: tb/tb_qdec_bin_arb.sv
// Directed bench for qdec_bin_arb with a bin scoreboard.
module tb_qdec_bin_arb;

`ifdef QDEC_BIN_ARB_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    typedef struct {
        logic [3:0] gnt;
        logic       bin;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    exp_t sb[$];

    qdec_bin_arb_if bus ();

    qdec_bin_arb dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .arb_io (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, 32'(bus.gnt), 0);
        check({tag, "_bin_vld"}, 32'(bus.bin_vld), 0);
        check({tag, "_bin_out"}, 32'(bus.bin_out), 0);
        check({tag, "_ctx_addr"}, 32'(bus.eng_ctx_addr), 0);
        check({tag, "_ctx_vld"}, 32'(bus.eng_ctx_addr_vld), 0);
        check({tag, "_dec_run"}, 32'(bus.eng_dec_run), 0);
        check({tag, "_ep_mode"}, 32'(bus.eng_ep_mode), 0);
        check({tag, "_busy"}, 32'(bus.busy), 0);
        check({tag, "_timeout"}, 32'(bus.timeout_err), 0);
    endtask

    // Acts as the engine for one transaction: answers dec_run after 'delay' cycles,
    // pushes the expected result, and returns in the cycle bin_vld is seen.
    task automatic serve(input logic [3:0] exp_gnt, input logic bin, input int delay,
                         input bit chk_ep);
        int   cnt;
        int   runs;
        bit   done;
        exp_t e;
        cnt  = -1;
        runs = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            tick();
            bus.eng_bin_vld = 1'b0;
            if (bus.gnt != 4'b0000) check("gnt_owner", 32'(bus.gnt), 32'(exp_gnt));
            if (chk_ep && bus.gnt != 4'b0000) begin
                check("ep_ctx_vld", 32'(bus.eng_ctx_addr_vld), 0);
                check("ep_mode", 32'(bus.eng_ep_mode), 1);
            end
            if (bus.eng_dec_run) begin
                runs++;
                cnt = 0;
            end else if (cnt >= 0) begin
                cnt++;
            end
            if (cnt == delay) begin
                bus.eng_bin_vld = 1'b1;
                bus.eng_bin     = bin;
                e.gnt = exp_gnt;
                e.bin = bin;
                sb.push_back(e);
                cnt = -1;
            end
            if (bus.bin_vld != 4'b0000) begin
                if (sb.size() == 0) begin
                    check("sb_size", 32'(sb.size()), 1);
                end else begin
                    e = sb.pop_front();
                    check("bin_vld", 32'(bus.bin_vld), 32'(e.gnt));
                    check("bin_out", 32'(bus.bin_out), 32'(e.bin));
                end
                done = 1'b1;
            end
        end
        check("txn_done", 32'(done), 1);
        check("dec_run_cnt", 32'(runs), 1);
    endtask

    initial begin
        logic [3:0] order [5];
        bit         seen;
        bit         early;
        n_cmp = 0;
        n_err = 0;
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100;
        order[3] = 4'b1000; order[4] = 4'b0001;

        rst_n           = 1'b0;
        bus.req         = 4'b0000;
        bus.lock        = 4'b0000;
        bus.ctx_addr_in = 40'd0;
        bus.ep_mode_in  = 4'b0000;
        bus.eng_dec_rdy = 1'b1;
        bus.eng_bin     = 1'b0;
        bus.eng_bin_vld = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;

        // Round-robin with all requesting: 0,1,2,3,0.
        bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) serve(order[i], logic'(i % 2 == 0), 1, 1'b0);
        bus.req = 4'b0000;
        repeat (2) tick();
        check("rr_idle_gnt", 32'(bus.gnt), 0);
        check("rr_idle_busy", 32'(bus.busy), 0);

        // Single requester 2: context path timing and bin return.
        bus.ctx_addr_in = {10'h3c3, 10'h155, 10'h2aa, 10'h0f0};
        bus.req = 4'b0100;
        tick();
        check("r2_gnt", 32'(bus.gnt), 32'h4);
        check("r2_ctx_vld", 32'(bus.eng_ctx_addr_vld), 1);
        check("r2_ctx_addr", 32'(bus.eng_ctx_addr), 32'h155);
        check("r2_busy", 32'(bus.busy), 1);
        tick();
        check("r2_ctx_vld_off", 32'(bus.eng_ctx_addr_vld), 0);
        check("r2_run_early", 32'(bus.eng_dec_run), 0);
        tick();
        check("r2_run", 32'(bus.eng_dec_run), 1);
        tick();
        check("r2_run_off", 32'(bus.eng_dec_run), 0);
        bus.eng_bin     = 1'b1;
        bus.eng_bin_vld = 1'b1;
        tick();
        bus.eng_bin_vld = 1'b0;
        check("r2_bin_vld", 32'(bus.bin_vld), 32'h4);
        check("r2_bin_out", 32'(bus.bin_out), 1);
        bus.req = 4'b0000;
        tick();
        check("r2_bin_vld_off", 32'(bus.bin_vld), 0);
        check("r2_gnt_off", 32'(bus.gnt), 0);

        // Requester 3 in bypass mode.
        bus.ep_mode_in = 4'b1000;
        bus.req        = 4'b1000;
        serve(4'b1000, 1'b0, 2, 1'b1);
        bus.req        = 4'b0000;
        bus.ep_mode_in = 4'b0000;
        tick();

        // Locked ownership for three bins while requester 0 waits.
        bus.lock = 4'b0010;
        bus.req  = 4'b0010;
        serve(4'b0010, 1'b1, 1, 1'b0);
        bus.req  = 4'b0011;
        serve(4'b0010, 1'b0, 3, 1'b0);
        serve(4'b0010, 1'b1, 1, 1'b0);
        bus.req  = 4'b0001;
        bus.lock = 4'b0000;
        serve(4'b0001, 1'b1, 1, 1'b0);
        bus.req  = 4'b0000;
        bus.eng_dec_rdy = 1'b0;
        repeat (2) tick();

        // Engine not ready: no dec_run until ready rises.
        bus.req = 4'b0001;
        repeat (2) tick();
        for (int i = 0; i < 10; i++) begin
            tick();
            check("nrdy_no_run", 32'(bus.eng_dec_run), 0);
        end
        bus.eng_dec_rdy = 1'b1;
        serve(4'b0001, 1'b0, 2, 1'b0);
        bus.req = 4'b0000;
        tick();

        // Reset in WAIT_BIN abandons the transaction; late engine bin is ignored.
        bus.req = 4'b0100;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = bus.eng_dec_run;
        end
        check("rst_run_seen", 32'(seen), 1);
        repeat (3) tick();
        check("rst_wait_busy", 32'(bus.busy), 1);
        rst_n = 1'b0;
        tick();
        check_all_zero("midrst");
        tick();
        rst_n           = 1'b1;
        bus.req         = 4'b0000;
        bus.eng_bin     = 1'b1;
        bus.eng_bin_vld = 1'b1;
        tick();
        bus.eng_bin_vld = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("postrst_bin_vld", 32'(bus.bin_vld), 0);
            check("postrst_gnt", 32'(bus.gnt), 0);
        end

        // Pointer reset: requester 0 first.
        bus.req = 4'b1111;
        serve(4'b0001, 1'b1, 1, 1'b0);
        bus.req = 4'b0000;
        tick();

        // Withheld engine bin: watchdog behaviour.
        bus.req = 4'b0010;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            seen = bus.eng_dec_run;
        end
        check("to_run_seen", 32'(seen), 1);
        early = 1'b0;
        for (int i = 0; i < 255; i++) begin
            tick();
            if (bus.timeout_err !== 1'b0 || bus.bin_vld !== 4'b0000) early = 1'b1;
        end
        check("to_early", 32'(early), 0);
        tick();
        check("to_pulse", 32'(bus.timeout_err), 32'(TimeoutEn));
        check("to_gnt", 32'(bus.gnt), TimeoutEn ? 32'h0 : 32'h2);
        check("to_bin_vld", 32'(bus.bin_vld), 0);
        bus.req = 4'b0000;
        tick();
        check("to_clear", 32'(bus.timeout_err), 0);
        rst_n = 1'b0;
        tick();
        check_all_zero("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/qdec_bin_arb.md
QDEC_BIN_ARB -- requirements
Module: qdec_bin_arb

Interface
REQ-001 clk  input  1  clock; all logic on posedge clk.
REQ-002 rst_n  input  1  reset, synchronous, active-low.
REQ-003 req  input  4  per-requester bin request, level; index 0=CTU/SAO, 1=CU, 2=PU, 3=TU sub-FSM.
REQ-004 lock  input  4  per-requester hold-grant across consecutive bins of one syntax element.
REQ-005 ctx_addr_in  input  40  packed 4x10 context addresses; requester i at bits [10i+9:10i].
REQ-006 ep_mode_in  input  4  per-requester bypass-mode select.
REQ-007 gnt  output  4  one-hot current grant; all-zero when no owner.
REQ-008 bin_out  output  1  decoded bin returned to the owner.
REQ-009 bin_vld  output  4  one-cycle one-hot bin-valid pulse to the owner.
REQ-010 eng_ctx_addr / eng_ctx_addr_vld  output  10 / 1  context fetch address and strobe to the arithmetic engine.
REQ-011 eng_dec_run / eng_ep_mode  output  1 / 1  decode-start pulse and bypass flag to the engine.
REQ-012 eng_dec_rdy, eng_bin, eng_bin_vld  input  1 each  engine ready, decoded bin, bin strobe.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 timeout_err  output  1  one-cycle watchdog error pulse (see Configuration).

Function
REQ-015 FSM states IDLE, ISSUE, RUN, WAIT_BIN, DONE, LOCKED; all outputs registered.
REQ-016 IDLE: if any req set, grant round-robin starting at rr_ptr+1 (mod 4); next cycle gnt one-hot, state ISSUE; no req -> stay.
REQ-017 ISSUE (1 cycle): eng_ctx_addr = owner's ctx_addr_in slice; eng_ctx_addr_vld = !ep_mode_in[owner]; eng_ep_mode = ep_mode_in[owner]; -> RUN.
REQ-018 RUN: eng_dec_run pulses exactly one cycle, in the first cycle after entering RUN where eng_dec_rdy was sampled 1; then -> WAIT_BIN; earliest eng_dec_run is 2 cycles after eng_ctx_addr_vld.
REQ-019 WAIT_BIN: on eng_bin_vld, capture eng_bin -> DONE.
REQ-020 DONE (1 cycle): bin_out = captured bin, bin_vld[owner]=1; rr_ptr <= owner; sample lock[owner]: 1 -> LOCKED (gnt kept), 0 -> IDLE (gnt cleared).
REQ-021 LOCKED: req[owner]=1 -> ISSUE with same owner; lock[owner]=0 and req[owner]=0 -> IDLE, gnt cleared; other requesters ignored.
REQ-022 Requester holds req, ctx_addr_in, ep_mode_in stable from request until bin_vld; drops req no later than the cycle after bin_vld; arbiter never samples req in DONE.
REQ-023 Minimum latency req (IDLE) -> bin_vld: 4 cycles plus engine decode time.
REQ-024 eng_bin_vld outside WAIT_BIN is ignored; eng_dec_run never asserted outside RUN.
REQ-025 req change by non-owners during a transaction has no effect until next IDLE arbitration.

Reset
REQ-026 rst_n=0: state IDLE, gnt=0, bin_vld=0, bin_out=0, eng_ctx_addr=0, eng_ctx_addr_vld=0, eng_dec_run=0, eng_ep_mode=0, busy=0, timeout_err=0, rr_ptr=3 (requester 0 highest priority first), watchdog=0.
REQ-027 Reset mid-transaction abandons it: no bin_vld issued; engine result arriving after reset is ignored.

Configuration
REQ-028 Macro QDEC_BIN_ARB_TIMEOUT_EN defined: 8-bit watchdog cleared on WAIT_BIN entry, increments each WAIT_BIN cycle; reaching 255 without eng_bin_vld -> timeout_err pulse 1 cycle, no bin_vld, gnt cleared, state IDLE, rr_ptr <= owner.
REQ-029 Macro undefined: no watchdog logic; timeout_err tied 0; WAIT_BIN waits indefinitely.

Verification
REQ-030 After reset, req=4'b1111, all ep=0, dec_rdy=1 -> grants in order 0,1,2,3,0; each bin_vld one-hot matches gnt.
REQ-031 req[2] alone, ctx_addr_in[29:20]=10'h155, ep=0 -> eng_ctx_addr=10'h155 with vld 1 cycle, eng_dec_run 2 cycles later; eng_bin=1 -> bin_out=1, bin_vld=4'b0100.
REQ-032 req[3] ep=1 -> eng_ctx_addr_vld stays 0, eng_ep_mode=1 throughout transaction.
REQ-033 lock[1]=1, req[1] for 3 bins while req[0]=1 -> gnt stays 4'b0010 for all 3 bins; lock drops -> next grant 4'b0001.
REQ-034 dec_rdy=0 for 10 cycles in RUN -> no eng_dec_run; dec_rdy rises -> single pulse; rst_n=0 during WAIT_BIN -> all outputs 0 next cycle, no bin_vld.
REQ-035 With QDEC_BIN_ARB_TIMEOUT_EN, eng_bin_vld withheld -> timeout_err 1 cycle after 255 WAIT_BIN cycles, gnt=0; without macro timeout_err stays 0.
